// File: rtl/rd_ptr_empty_ctrl.sv
// ---------------------------------------------------------------------------
// rd_ptr_empty_ctrl
// Read-domain pointer and empty-flag controller of the async FIFO.
//   - Owns the read pointer: binary (RAM read address) and Gray (to the
//     read-to-write synchronizer).
//   - Compares the next Gray read pointer with the already-synchronized
//     Gray write pointer to produce a registered empty flag.
//   - Flags reads attempted while empty with a one-cycle underflow pulse.
//
// Optional feature macro: RD_LEVEL_EN
//   defined   : registered fill level and almost-empty flag
//   undefined : rd_level tied to 0, rd_almost_empty tied to 1
//
// Ports
//   rd_clk           in   read-domain clock, all state on posedge
//   rd_rst           in   asynchronous active-high reset
//   rd_en            in   read request from consumer
//   rd_sync_to_wr    in   synchronized write pointer, Gray, ADDR_WIDTH+1 bits
//   rd_addr          out  RAM read address (low bits of binary read pointer)
//   rd_ptr           out  registered Gray read pointer
//   rd_empty         out  FIFO empty, registered
//   rd_underflow     out  one-cycle pulse, read attempted while empty
//   rd_level         out  entries available (RD_LEVEL_EN only)
//   rd_almost_empty  out  level <= ALMOST_EMPTY_THR (RD_LEVEL_EN only)
// ---------------------------------------------------------------------------
module rd_ptr_empty_ctrl #(
   parameter int unsigned ADDR_WIDTH       = 6,
   parameter int unsigned ALMOST_EMPTY_THR = 4
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH:0]   rd_sync_to_wr,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH:0]   rd_ptr,
   output logic                  rd_empty,
   output logic                  rd_underflow,
   output logic [ADDR_WIDTH:0]   rd_level,
   output logic                  rd_almost_empty
);

   localparam int unsigned PW = ADDR_WIDTH + 1;

   logic [PW-1:0] rd_bin;
   logic [PW-1:0] rd_bin_next;
   logic [PW-1:0] rd_gray_next;
   logic          rd_inc;

   // Next pointer: a read is accepted only when the FIFO is not empty
   always_comb begin
      rd_inc       = rd_en & ~rd_empty;
      rd_bin_next  = rd_bin + PW'(rd_inc);
      rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
   end

   // Pointer, empty and underflow registers
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         rd_bin       <= '0;
         rd_ptr       <= '0;
         rd_empty     <= 1'b1;
         rd_underflow <= 1'b0;
      end else begin
         rd_bin       <= rd_bin_next;
         rd_ptr       <= rd_gray_next;
         // Full-width compare: MSB distinguishes empty from a full lap
         rd_empty     <= (rd_gray_next == rd_sync_to_wr);
         rd_underflow <= rd_en & rd_empty;
      end
   end

   assign rd_addr = rd_bin[ADDR_WIDTH-1:0];

`ifdef RD_LEVEL_EN
   logic [PW-1:0] wr_bin;
   logic [PW-1:0] level_next;

   // Gray-to-binary of the synchronized write pointer (XOR prefix chain)
   always_comb begin
      wr_bin         = '0;
      wr_bin[PW-1]   = rd_sync_to_wr[PW-1];
      for (int i = int'(PW) - 2; i >= 0; i--) begin
         wr_bin[i] = wr_bin[i+1] ^ rd_sync_to_wr[i];
      end
      level_next = wr_bin - rd_bin_next;
   end

   // Level flags track the same next pointer as rd_empty
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         rd_level        <= '0;
         rd_almost_empty <= 1'b1;
      end else begin
         rd_level        <= level_next;
         rd_almost_empty <= (level_next <= PW'(ALMOST_EMPTY_THR));
      end
   end
`else
   assign rd_level        = '0;
   assign rd_almost_empty = 1'b1;
`endif

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rd_ptr_empty_ctrl
// Directed self-checking bench for rd_ptr_empty_ctrl (ADDR_WIDTH=6,
// ALMOST_EMPTY_THR=4). Inputs change 1 time unit after the rising edge and
// outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_rd_ptr_empty_ctrl;

   localparam int unsigned AW = 6;

   logic          rd_clk;
   logic          rd_rst;
   logic          rd_en;
   logic [AW:0]   rd_sync_to_wr;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   rd_ptr;
   logic          rd_empty;
   logic          rd_underflow;
   logic [AW:0]   rd_level;
   logic          rd_almost_empty;

   int total;
   int bad;

   rd_ptr_empty_ctrl #(.ADDR_WIDTH(AW), .ALMOST_EMPTY_THR(4)) dut (
      .rd_clk          (rd_clk),
      .rd_rst          (rd_rst),
      .rd_en           (rd_en),
      .rd_sync_to_wr   (rd_sync_to_wr),
      .rd_addr         (rd_addr),
      .rd_ptr          (rd_ptr),
      .rd_empty        (rd_empty),
      .rd_underflow    (rd_underflow),
      .rd_level        (rd_level),
      .rd_almost_empty (rd_almost_empty)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic do_reset();
      rd_rst = 1'b1;
      rd_en  = 1'b0;
      tick();
      rd_rst = 1'b0;
   endtask

   task automatic test_reset();
      rd_rst        = 1'b1;
      rd_en         = 1'b1;
      rd_sync_to_wr = 7'b0001111;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++; if (rd_ptr !== 7'd0) begin bad++; $display("FAIL reset_ptr cyc%0d got=%b exp=0000000", c, rd_ptr); end
         total++; if (rd_addr !== 6'd0) begin bad++; $display("FAIL reset_addr cyc%0d got=%0d exp=0", c, rd_addr); end
         total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL reset_empty cyc%0d got=%b exp=1", c, rd_empty); end
         total++; if (rd_underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow cyc%0d got=%b exp=0", c, rd_underflow); end
         total++; if (rd_almost_empty !== 1'b1) begin bad++; $display("FAIL reset_almost_empty cyc%0d got=%b exp=1", c, rd_almost_empty); end
         total++; if (rd_level !== 7'd0) begin bad++; $display("FAIL reset_level cyc%0d got=%0d exp=0", c, rd_level); end
      end
      rd_rst        = 1'b0;
      rd_en         = 1'b0;
      rd_sync_to_wr = 7'd0;
   endtask

   task automatic test_underflow();
      rd_sync_to_wr = 7'd0;
      rd_en         = 1'b1;
      tick();
      rd_en = 1'b0;
      total++; if (rd_underflow !== 1'b1) begin bad++; $display("FAIL uf_pulse got=%b exp=1", rd_underflow); end
      total++; if (rd_ptr !== 7'd0) begin bad++; $display("FAIL uf_ptr_hold got=%b exp=0000000", rd_ptr); end
      total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL uf_empty got=%b exp=1", rd_empty); end
      tick();
      total++; if (rd_underflow !== 1'b0) begin bad++; $display("FAIL uf_one_cycle got=%b exp=0", rd_underflow); end
      total++; if (rd_addr !== 6'd0) begin bad++; $display("FAIL uf_addr_hold got=%0d exp=0", rd_addr); end
   endtask

   task automatic test_three_reads();
      rd_sync_to_wr = 7'b0000010;
      tick();
      total++; if (rd_empty !== 1'b0) begin bad++; $display("FAIL r3_empty_deassert got=%b exp=0", rd_empty); end
      total++; if (rd_addr !== 6'd0) begin bad++; $display("FAIL r3_addr_start got=%0d exp=0", rd_addr); end
      rd_en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++; if (rd_addr !== 6'(i)) begin bad++; $display("FAIL r3_addr step%0d got=%0d exp=%0d", i, rd_addr, i); end
         total++; if (rd_empty !== (i == 3)) begin bad++; $display("FAIL r3_empty step%0d got=%b exp=%b", i, rd_empty, (i == 3)); end
         total++; if (rd_underflow !== 1'b0) begin bad++; $display("FAIL r3_underflow step%0d got=%b exp=0", i, rd_underflow); end
      end
      rd_en = 1'b0;
      total++; if (rd_ptr !== 7'b0000010) begin bad++; $display("FAIL r3_ptr_end got=%b exp=0000010", rd_ptr); end
   endtask

   task automatic test_wrap();
      logic [AW:0]   prev;
      logic [AW-1:0] exp_addr;
      do_reset();
      rd_sync_to_wr = 7'b1100000;
      tick();
      total++; if (rd_empty !== 1'b0) begin bad++; $display("FAIL wrap_empty_deassert got=%b exp=0", rd_empty); end
      rd_en    = 1'b1;
      prev     = rd_ptr;
      exp_addr = '0;
      for (int i = 1; i <= 64; i++) begin
         tick();
         exp_addr = exp_addr + 6'd1;
         total++; if ($countones(rd_ptr ^ prev) !== 1) begin bad++; $display("FAIL wrap_gray_step%0d prev=%b got=%b exp=one-bit-change", i, prev, rd_ptr); end
         total++; if (rd_addr !== exp_addr) begin bad++; $display("FAIL wrap_addr step%0d got=%0d exp=%0d", i, rd_addr, exp_addr); end
         total++; if (rd_empty !== (i == 64)) begin bad++; $display("FAIL wrap_empty step%0d got=%b exp=%b", i, rd_empty, (i == 64)); end
         prev = rd_ptr;
      end
      rd_en = 1'b0;
      total++; if (rd_ptr !== 7'b1100000) begin bad++; $display("FAIL wrap_ptr_end got=%b exp=1100000", rd_ptr); end
      total++; if (rd_addr !== 6'd0) begin bad++; $display("FAIL wrap_addr_end got=%0d exp=0", rd_addr); end
   endtask

   // Read and sync change in the same cycle: read judged on current empty
   task automatic test_same_cycle();
      rd_en         = 1'b1;
      rd_sync_to_wr = 7'b1100001;
      tick();
      total++; if (rd_underflow !== 1'b1) begin bad++; $display("FAIL same_underflow got=%b exp=1", rd_underflow); end
      total++; if (rd_ptr !== 7'b1100000) begin bad++; $display("FAIL same_ptr_hold got=%b exp=1100000", rd_ptr); end
      total++; if (rd_empty !== 1'b0) begin bad++; $display("FAIL same_empty got=%b exp=0", rd_empty); end
      tick();
      rd_en = 1'b0;
      total++; if (rd_ptr !== 7'b1100001) begin bad++; $display("FAIL same_ptr_adv got=%b exp=1100001", rd_ptr); end
      total++; if (rd_addr !== 6'd1) begin bad++; $display("FAIL same_addr got=%0d exp=1", rd_addr); end
      total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL same_empty_last got=%b exp=1", rd_empty); end
      total++; if (rd_underflow !== 1'b0) begin bad++; $display("FAIL same_underflow_clr got=%b exp=0", rd_underflow); end
   endtask

   task automatic test_level();
      logic [AW:0] exp_lvl;
      logic        exp_ae;
      do_reset();
      rd_sync_to_wr = 7'b0001111;
      tick();
`ifdef RD_LEVEL_EN
      exp_lvl = 7'd10; exp_ae = 1'b0;
`else
      exp_lvl = 7'd0;  exp_ae = 1'b1;
`endif
      total++; if (rd_level !== exp_lvl) begin bad++; $display("FAIL lvl_initial got=%0d exp=%0d", rd_level, exp_lvl); end
      total++; if (rd_almost_empty !== exp_ae) begin bad++; $display("FAIL ae_initial got=%b exp=%b", rd_almost_empty, exp_ae); end
      total++; if (rd_empty !== 1'b0) begin bad++; $display("FAIL lvl_empty got=%b exp=0", rd_empty); end
      rd_en = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
`ifdef RD_LEVEL_EN
         exp_lvl = 7'(10 - i); exp_ae = ((10 - i) <= 4);
`endif
         total++; if (rd_level !== exp_lvl) begin bad++; $display("FAIL lvl read%0d got=%0d exp=%0d", i, rd_level, exp_lvl); end
         total++; if (rd_almost_empty !== exp_ae) begin bad++; $display("FAIL ae read%0d got=%b exp=%b", i, rd_almost_empty, exp_ae); end
      end
      rd_en = 1'b0;
      total++; if (rd_addr !== 6'd6) begin bad++; $display("FAIL lvl_addr got=%0d exp=6", rd_addr); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      rd_sync_to_wr = 7'b0001111;
      tick();
      rd_en = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      rd_en = 1'b0;
      total++; if (rd_addr !== 6'd5) begin bad++; $display("FAIL mid_addr_pre got=%0d exp=5", rd_addr); end
      rd_rst = 1'b1;
      #1;
      total++; if (rd_addr !== 6'd0) begin bad++; $display("FAIL mid_async_addr got=%0d exp=0", rd_addr); end
      total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL mid_async_empty got=%b exp=1", rd_empty); end
      total++; if (rd_ptr !== 7'd0) begin bad++; $display("FAIL mid_async_ptr got=%b exp=0000000", rd_ptr); end
      tick();
      rd_rst = 1'b0;
      #1;
      total++; if (rd_empty !== 1'b1) begin bad++; $display("FAIL mid_release_empty got=%b exp=1", rd_empty); end
      tick();
      total++; if (rd_empty !== 1'b0) begin bad++; $display("FAIL mid_post_empty got=%b exp=0", rd_empty); end
      total++; if (rd_addr !== 6'd0) begin bad++; $display("FAIL mid_post_addr got=%0d exp=0", rd_addr); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_underflow();
      test_three_reads();
      test_wrap();
      test_same_cycle();
      test_level();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
